// File: rtl/instr_encoder_loader.sv
// Re-encodes decoded RV32I field bundles into 32-bit words and streams them
// into instruction memory at consecutive word addresses.
module instr_encoder_loader #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        fn3,
  input  logic              fn7_5,
  input  logic [11:0]       imm,
  input  logic [19:0]       imm_uj,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg;
  logic [CNT_W-1:0]    remaining_reg;
  logic                mem_we_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [31:0]         mem_wdata_reg;
  logic                err_reg;
  logic [31:0]         enc_word;
  logic                enc_bad;
  logic                accept;

  assign accept    = in_valid & in_ready;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign err       = err_reg;

  // Immediate scatter mirrors the decoder's packing of imm / imm_uj.
  always_comb begin
    enc_word = NOP_WORD;
    enc_bad  = 1'b0;
    case (opcode)
      OP_R:                      enc_word = {1'b0, fn7_5, 5'b0, rs2, rs1, fn3, rd, opcode};
      OP_IMM, OP_LOAD, OP_JALR:  enc_word = {imm, rs1, fn3, rd, opcode};
      OP_STORE:                  enc_word = {imm[11:5], rs2, rs1, fn3, imm[4:0], opcode};
      OP_BRANCH:                 enc_word = {imm[11], imm[9:4], rs2, rs1, fn3, imm[3:0], imm[10], opcode};
      OP_JAL:                    enc_word = {imm_uj[19], imm_uj[9:0], imm_uj[10], imm_uj[18:11], rd, opcode};
      OP_LUI, OP_AUIPC:          enc_word = {imm_uj, rd, opcode};
      default:                   enc_bad  = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = (count == '0) ? FLUSH : LOAD;
      end
      LOAD: begin
        busy     = 1'b1;
        in_ready = (remaining_reg != '0);
        if (accept && remaining_reg == CNT_W'(1)) state_next = FLUSH;
      end
      FLUSH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The accepted word is written the following cycle from these registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg      <= '0;
      remaining_reg <= '0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      mem_we_reg <= accept;
      if (state_reg == IDLE && start) begin
        addr_reg      <= base_addr & ~ADDR_W'(3);
        remaining_reg <= count;
        err_reg       <= 1'b0;
      end
      if (accept) begin
        mem_addr_reg  <= addr_reg;
        mem_wdata_reg <= enc_word;
        addr_reg      <= addr_reg + ADDR_W'(4);
        remaining_reg <= remaining_reg - CNT_W'(1);
        if (enc_bad) err_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: expected writes are queued at
// acceptance and checked (address, word, cycle) when mem_we appears.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [7:0]  count = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  opcode = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]  fn3 = '0;
  logic        fn7_5 = 1'b0;
  logic [11:0] imm = '0;
  logic [19:0] imm_uj = '0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy, done, err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [31:0] exp_addr = '0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  instr_encoder_loader #(.ADDR_W(32), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode), .rd(rd), .rs1(rs1),
    .rs2(rs2), .fn3(fn3), .fn7_5(fn7_5), .imm(imm), .imm_uj(imm_uj),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Write monitor: every mem_we must match the head of the scoreboard, on its due cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: observed addr=%h data=%h, required no write", mem_addr, mem_wdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data || cyc != e.due) begin
          miscompares++;
          $display("FAIL write: observed addr=%h data=%h cyc=%0d, required addr=%h data=%h cyc=%0d",
                   mem_addr, mem_wdata, cyc, e.addr, e.data, e.due);
        end else begin
          $display("write addr=%h data=%h cyc=%0d", mem_addr, mem_wdata, cyc);
        end
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      exp_t e;
      vectors++;
      miscompares++;
      e = sb.pop_front();
      $display("FAIL missing_write: observed mem_we=%b, required write addr=%h data=%h", mem_we, e.addr, e.data);
    end
  end

  task automatic do_start(input logic [31:0] b, input logic [7:0] c, input string tag);
    base_addr = b;
    count     = c;
    start     = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    exp_addr = b & 32'hFFFF_FFFC;
    vectors++;
    if (busy !== (c != 8'd0)) begin
      miscompares++;
      $display("FAIL %s_busy_after_start: observed %b, required %b", tag, busy, (c != 8'd0));
    end
  endtask

  task automatic send(input logic [6:0] op, input logic [4:0] f_rd, input logic [4:0] f_rs1,
                      input logic [4:0] f_rs2, input logic [2:0] f_fn3, input logic f_fn7,
                      input logic [11:0] f_imm, input logic [19:0] f_uj, input logic [31:0] word,
                      input string tag);
    bit took = 0;
    opcode = op; rd = f_rd; rs1 = f_rs1; rs2 = f_rs2; fn3 = f_fn3;
    fn7_5 = f_fn7; imm = f_imm; imm_uj = f_uj;
    in_valid = 1'b1;
    for (int t = 0; t < 20 && !took; t++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        took = 1;
        sb.push_back('{exp_addr, word, cyc + 1});
        $display("accept %s op=%b expect addr=%h word=%h", tag, op, exp_addr, word);
        exp_addr += 32'd4;
      end
    end
    vectors++;
    if (!took) begin
      miscompares++;
      $display("FAIL %s_accept: observed in_ready=%b, required acceptance within 20 cycles", tag, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL %s_done: observed no pulse, required done within 20 cycles", tag);
    end else begin
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_busy_at_done: observed %b, required 0", tag, busy);
      end
    end
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_after_done: observed done=%b in_ready=%b, required 0 0", tag, done, in_ready);
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s_pending_writes: observed %0d outstanding, required 0", tag, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({in_ready, mem_we, busy, done, err} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: observed rdy/we/busy/done/err=%b, required 00000",
               {in_ready, mem_we, busy, done, err});
    end
    vectors++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_data: observed addr=%h data=%h, required 0 0", mem_addr, mem_wdata);
    end
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    do_start(32'h100, 8'd1, "single");
    send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 12'h0, 20'h0, 32'h002081B3, "add");
    wait_done("single");
  endtask

  task automatic test_back_to_back();
    do_start(32'h0, 8'd4, "b2b");
    send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 12'h0,   20'h0, 32'h402081B3, "sub");
    send(7'b0010011, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 12'hFFF, 20'h0, 32'hFFF00293, "addi");
    send(7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 12'h008, 20'h0, 32'h0020A423, "sw");
    send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 12'h004, 20'h0, 32'h00208463, "beq");
    wait_done("b2b");
  endtask

  task automatic test_jal();
    do_start(32'h203, 8'd1, "jal");
    send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 12'h0, 20'h00004, 32'h008000EF, "jal");
    wait_done("jal");
  endtask

  task automatic test_bad_opcode();
    do_start(32'h400, 8'd2, "err");
    send(7'h7F, 5'd1, 5'd2, 5'd3, 3'd1, 1'b0, 12'h0, 20'h0, 32'h00000013, "bad");
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_after_bad: observed %b, required 1", err);
    end
    send(7'b0110111, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 12'h0, 20'hABCDE, 32'hABCDE0B7, "lui");
    wait_done("err");
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky: observed %b, required 1", err);
    end
  endtask

  task automatic test_count_zero();
    do_start(32'h500, 8'd0, "zero");
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_cleared_by_start: observed %b, required 0", err);
    end
    wait_done("zero");
  endtask

  task automatic test_start_while_busy();
    do_start(32'h40, 8'd2, "busy");
    send(7'b0010011, 5'd7, 5'd6, 5'd0, 3'd4, 1'b0, 12'h123, 20'h0, 32'h12334393, "xori");
    start = 1'b1; base_addr = 32'h1000; count = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    send(7'b0000011, 5'd8, 5'd9, 5'd0, 3'd2, 1'b0, 12'h010, 20'h0, 32'h0104A403, "lw");
    wait_done("busy");
  endtask

  task automatic test_valid_toggle_reset();
    do_start(32'h80, 8'd2, "toggle");
    send(7'b0010111, 5'd4, 5'd0, 5'd0, 3'd0, 1'b0, 12'h0, 20'h12345, 32'h12345217, "auipc");
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL toggle_ready_gap: observed %b, required 1", in_ready);
    end
    @(posedge clk); #1;
    send(7'b1100111, 5'd1, 5'd5, 5'd0, 3'd0, 1'b0, 12'h7F0, 20'h0, 32'h7F0280E7, "jalr");
    wait_done("toggle");

    do_start(32'h300, 8'd3, "midrst");
    send(7'b0110011, 5'd10, 5'd11, 5'd12, 3'd7, 1'b0, 12'h0, 20'h0, 32'h00C5F533, "and");
    @(posedge clk); #1;
    opcode = 7'h7F; in_valid = 1'b1;
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({in_ready, mem_we, busy, done, err} !== 5'b0) begin
      miscompares++;
      $display("FAIL midrst_ctrl: observed rdy/we/busy/done/err=%b, required 00000",
               {in_ready, mem_we, busy, done, err});
    end
    vectors++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      miscompares++;
      $display("FAIL midrst_data: observed addr=%h data=%h, required 0 0", mem_addr, mem_wdata);
    end
    in_valid = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL midrst_after: observed in_ready=%b busy=%b pending=%0d, required 0 0 0",
               in_ready, busy, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_jal();
    test_bad_opcode();
    test_count_zero();
    test_start_while_busy();
    test_valid_toggle_reset();
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
